// File: rtl/reg_file_if.sv
// reg_file_if
//   Operand-read / write-back bus of the RV32I integer register file.
//   master : controller/datapath side (drives addresses and write-back data)
//   slave  : register file side (returns read data)
//   Signals:
//     readReg1, readReg2  rs1 / rs2 addresses
//     writeReg            rd address
//     writeData           write-back data (ALUOut or MDR)
//     regWrite            write enable, sampled at the rising clk edge
//     dbgAddr             debug read address
//     readData1/2         x[readReg1] / x[readReg2], feed the A / B latches
//     dbgData             x[dbgAddr]
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   readReg1;
  logic [AW-1:0]   readReg2;
  logic [AW-1:0]   writeReg;
  logic [XLEN-1:0] writeData;
  logic            regWrite;
  logic [AW-1:0]   dbgAddr;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic [XLEN-1:0] dbgData;

  modport master (
    output readReg1, readReg2, writeReg, writeData, regWrite, dbgAddr,
    input  readData1, readData2, dbgData
  );

  modport slave (
    input  readReg1, readReg2, writeReg, writeData, regWrite, dbgAddr,
    output readData1, readData2, dbgData
  );
endinterface

// File: rtl/reg_file.sv
// reg_file
//   Architectural integer register file x0..x31 for the multicycle RV32I core.
//   Two combinational operand read ports plus one debug read port; one
//   write port used by the write-back step. x0 reads as zero and ignores
//   writes. Reset is asynchronous and loads sp/gp with their boot values.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; restores the reset contents
//     rf     reg_file_if.slave bundle (addresses, write-back, read data)
//   Configuration macro:
//     REGFILE_BYPASS_EN  when defined, a read of the register being written
//                        this cycle returns writeData combinationally.
module reg_file #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_0800
) (
  input  logic      clk,
  input  logic      reset,
  reg_file_if.slave rf
);
  localparam int AW    = $clog2(NREGS);
  localparam int NPORT = 3;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;
  logic [AW-1:0]   raddr [NPORT];
  logic [XLEN-1:0] rdata [NPORT];

  // reset is folded in so a write coinciding with reset can never leak
  // into the bypass path.
  assign wr_en = rf.regWrite && !reset && (rf.writeReg != '0);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[rf.writeReg] = rf.writeData;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[2] <= XLEN'(SP_INIT);
      regs_q[3] <= XLEN'(GP_INIT);
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Port 0 = rs1, 1 = rs2, 2 = debug; all share identical read rules.
  always_comb begin
    raddr[0] = rf.readReg1;
    raddr[1] = rf.readReg2;
    raddr[2] = rf.dbgAddr;
    for (int p = 0; p < NPORT; p++) begin
      rdata[p] = regs_q[raddr[p]];
      if (raddr[p] == '0) begin
        rdata[p] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_en && (rf.writeReg == raddr[p])) begin
        rdata[p] = rf.writeData;
      end
`else
      else begin
        rdata[p] = regs_q[raddr[p]];
      end
`endif
    end
  end

  assign rf.readData1 = rdata[0];
  assign rf.readData2 = rdata[1];
  assign rf.dbgData   = rdata[2];
endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  reg_file_if #(.XLEN(32), .AW(5)) rf ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    rf.writeReg  = addr;
    rf.writeData = data;
    rf.regWrite  = 1'b1;
    @(posedge clk);
    #1;
    rf.regWrite  = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rf.readReg1  = '0;
    rf.readReg2  = '0;
    rf.writeReg  = '0;
    rf.writeData = '0;
    rf.regWrite  = 1'b0;
    rf.dbgAddr   = '0;

    // 1: reset contents, checked while reset is held and after release
    reset = 1'b1;
    rf.readReg1 = 5'd2;
    rf.readReg2 = 5'd3;
    rf.dbgAddr  = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp", rf.readData1, 32'h0000_0FFC);
    check("rst_gp", rf.readData2, 32'h0000_0800);
    check("rst_x31", rf.dbgData, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_sp", rf.readData1, 32'h0000_0FFC);
    check("post_rst_gp", rf.readData2, 32'h0000_0800);

    // 2: plain write, then write to x0 is discarded
    write_reg(5'd5, 32'd200000);
    rf.readReg2 = 5'd5;
    #2;
    check("wr_x5", rf.readData2, 32'd200000);
    write_reg(5'd0, 32'hDEAD_BEEF);
    rf.readReg1 = 5'd0;
    rf.dbgAddr  = 5'd0;
    #2;
    check("x0_rd1", rf.readData1, 32'h0);
    check("x0_dbg", rf.dbgData, 32'h0);
    // x0 is never bypassed, even while being written
    rf.writeReg  = 5'd0;
    rf.writeData = 32'h1234_5678;
    rf.regWrite  = 1'b1;
    #2;
    check("x0_during_wr", rf.readData1, 32'h0);
    rf.regWrite  = 1'b0;
    @(posedge clk);
    #1;

    // 3: same-edge read/write of x7
    write_reg(5'd7, 32'd11);
    rf.readReg1  = 5'd7;
    rf.dbgAddr   = 5'd7;
    rf.writeReg  = 5'd7;
    rf.writeData = 32'd99;
    rf.regWrite  = 1'b1;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("same_edge_rd1", rf.readData1, 32'd99);
    check("same_edge_dbg", rf.dbgData, 32'd99);
`else
    check("same_edge_rd1", rf.readData1, 32'd11);
    check("same_edge_dbg", rf.dbgData, 32'd11);
`endif
    @(posedge clk);
    #1;
    rf.regWrite = 1'b0;
    check("after_edge_rd1", rf.readData1, 32'd99);
    check("after_edge_dbg", rf.dbgData, 32'd99);

    // 4: asynchronous reset mid-cycle, write during reset dropped
    write_reg(5'd9, 32'd1234);
    rf.readReg1 = 5'd9;
    rf.readReg2 = 5'd2;
    #2;
    check("x9_before_rst", rf.readData1, 32'd1234);
    reset = 1'b1;
    #1;
    check("x9_async_rst", rf.readData1, 32'h0);
    check("sp_async_rst", rf.readData2, 32'h0000_0FFC);
    rf.writeReg  = 5'd9;
    rf.writeData = 32'd5555;
    rf.regWrite  = 1'b1;
    #1;
    check("x9_wr_in_rst_comb", rf.readData1, 32'h0);
    @(posedge clk);
    #1;
    rf.regWrite = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("x9_wr_in_rst", rf.readData1, 32'h0);

    // 5: three ports on the same register
    write_reg(5'd4, 32'hFFFF_FFFF);
    rf.readReg1 = 5'd4;
    rf.readReg2 = 5'd4;
    rf.dbgAddr  = 5'd4;
    #2;
    check("same_addr_rd1", rf.readData1, 32'hFFFF_FFFF);
    check("same_addr_rd2", rf.readData2, 32'hFFFF_FFFF);
    check("same_addr_dbg", rf.dbgData, 32'hFFFF_FFFF);

    // 6: fill x1..x31 with 100+i, read back pairwise
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(100 + i));
    end
    for (int i = 1; i < 32; i += 2) begin
      rf.readReg1 = 5'(i);
      rf.readReg2 = 5'((i + 1) % 32);
      rf.dbgAddr  = 5'(i);
      #2;
      check($sformatf("fill_rd1_x%0d", i), rf.readData1, 32'(100 + i));
      check($sformatf("fill_rd2_x%0d", (i + 1) % 32), rf.readData2,
            (i == 31) ? 32'h0 : 32'(101 + i));
      check($sformatf("fill_dbg_x%0d", i), rf.dbgData, 32'(100 + i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
